iter_divider: RTL and testbench

- Parametrised radix-2 restoring divider for the execution stage.
- Replaces the ad-hoc start/continue/cnt divider control with a clean valid/ready handshake, a flush input and a result tag.
- Computes quotient and remainder together, signed or unsigned, with fully defined divide-by-zero and signed-overflow results.
- The EX stage stalls while an accepted request has no returned result; the writeback select picks quotient (DIV/DIVU) or remainder (MOD/MODU).

---
 rtl/iter_divider.sv | 153 +++++++++++++++
 tb/tb_iter_divider.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// Radix-2 restoring divider producing quotient and remainder with a valid/ready
// request/response handshake, flush, and a tag carried alongside the result.
module iter_divider #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     dividend_i,
  input  logic [WIDTH-1:0]     divisor_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  input  logic                 flush_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [WIDTH-1:0]     quotient_o,
  output logic [WIDTH-1:0]     remainder_o,
  output logic [TAG_WIDTH-1:0] tag_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic [WIDTH-1:0]       rem_reg, rem_next;
  logic [WIDTH-1:0]       shift_reg, shift_next;
  logic [WIDTH-1:0]       dvsr_reg, dvsr_next;
  logic                   q_neg_reg, q_neg_next;
  logic                   r_neg_reg, r_neg_next;
  logic [TAG_WIDTH-1:0]   tag_reg, tag_next;
  logic [WIDTH-1:0]       quot_reg, quot_next;
  logic [WIDTH-1:0]       remo_reg, remo_next;
  logic [TAG_WIDTH-1:0]   tago_reg, tago_next;

  logic                   dvd_neg, dvs_neg;
  logic [WIDTH-1:0]       dvd_mag, dvs_mag;
  logic [WIDTH:0]         rem_sh, diff;
  logic                   ge;
  logic [WIDTH-1:0]       rem_step, shift_step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rem_reg   <= '0;
      shift_reg <= '0;
      dvsr_reg  <= '0;
      q_neg_reg <= 1'b0;
      r_neg_reg <= 1'b0;
      tag_reg   <= '0;
      quot_reg  <= '0;
      remo_reg  <= '0;
      tago_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rem_reg   <= rem_next;
      shift_reg <= shift_next;
      dvsr_reg  <= dvsr_next;
      q_neg_reg <= q_neg_next;
      r_neg_reg <= r_neg_next;
      tag_reg   <= tag_next;
      quot_reg  <= quot_next;
      remo_reg  <= remo_next;
      tago_reg  <= tago_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rem_next   = rem_reg;
    shift_next = shift_reg;
    dvsr_next  = dvsr_reg;
    q_neg_next = q_neg_reg;
    r_neg_next = r_neg_reg;
    tag_next   = tag_reg;
    quot_next  = quot_reg;
    remo_next  = remo_reg;
    tago_next  = tago_reg;

    dvd_neg = signed_i & dividend_i[WIDTH-1];
    dvs_neg = signed_i & divisor_i[WIDTH-1];
    dvd_mag = dvd_neg ? -dividend_i : dividend_i;
    dvs_mag = dvs_neg ? -divisor_i : divisor_i;

    // A set top bit in the shifted remainder already exceeds any divisor,
    // so the subtraction is non-negative regardless of the borrow bit.
    rem_sh     = {rem_reg, shift_reg[WIDTH-1]};
    diff       = rem_sh - {1'b0, dvsr_reg};
    ge         = rem_sh[WIDTH] | ~diff[WIDTH];
    rem_step   = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    shift_step = {shift_reg[WIDTH-2:0], ge};

    if (flush_i) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (valid_i) begin
            tag_next   = tag_i;
            q_neg_next = dvd_neg ^ dvs_neg;
            r_neg_next = dvd_neg;
            if (divisor_i == '0) begin
              state_next = DONE;
              quot_next  = '1;
              remo_next  = dividend_i;
              tago_next  = tag_i;
            end else if (signed_i && dividend_i == MIN_VAL && divisor_i == '1) begin
              state_next = DONE;
              quot_next  = MIN_VAL;
              remo_next  = '0;
              tago_next  = tag_i;
            end else begin
              state_next = CALC;
              cnt_next   = '0;
              rem_next   = '0;
              shift_next = dvd_mag;
              dvsr_next  = dvs_mag;
            end
          end
        end
        CALC: begin
          rem_next   = rem_step;
          shift_next = shift_step;
          cnt_next   = cnt_reg + CW'(1);
          if (cnt_reg == CW'(WIDTH - 1)) begin
            state_next = DONE;
            quot_next  = q_neg_reg ? -shift_step : shift_step;
            remo_next  = r_neg_reg ? -rem_step : rem_step;
            tago_next  = tag_reg;
          end
        end
        DONE: begin
          if (ready_i) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign ready_o     = (state_reg == IDLE);
  assign valid_o     = (state_reg == DONE);
  assign quotient_o  = quot_reg;
  assign remainder_o = remo_reg;
  assign tag_o       = tago_reg;

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: a cycle-level reference model checked every
// cycle, plus directed transactions with hand-computed results and latencies.
module tb_iter_divider;
  localparam int W  = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_i = 1'b0, signed_i = 1'b0, flush_i = 1'b0, ready_i = 1'b0;
  logic [W-1:0]  dividend_i = '0, divisor_i = '0;
  logic [TW-1:0] tag_i = '0;
  logic          ready_o, valid_o;
  logic [W-1:0]  quotient_o, remainder_o;
  logic [TW-1:0] tag_o;

  int checks = 0;
  int errors = 0;

  iter_divider #(.WIDTH(W), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .signed_i(signed_i), .dividend_i(dividend_i), .divisor_i(divisor_i),
    .tag_i(tag_i), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .quotient_o(quotient_o), .remainder_o(remainder_o), .tag_o(tag_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Arithmetic reference: result and edges-after-accept until valid_o is seen.
  function automatic void ref_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == '0) begin
      q = '1; r = a; lat = 0;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = '0; lat = 0;
    end else begin
      lat = W;
      if (s) begin
        q = 32'(sa / sb);
        r = 32'(sa % sb);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  // Cycle-level model: busy from accept until handshake, result after m_left edges.
  bit            m_busy;
  int            m_left;
  logic [W-1:0]  m_q, m_r, p_q, p_r;
  logic [TW-1:0] m_tag, p_tag;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_left = 0; m_q = '0; m_r = '0; m_tag = '0;
    end else if (flush_i) begin
      m_busy = 0;
    end else if (m_busy && m_left == 0) begin
      if (ready_i) m_busy = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin m_q = p_q; m_r = p_r; m_tag = p_tag; end
    end else if (valid_i) begin
      ref_div(signed_i, dividend_i, divisor_i, p_q, p_r, m_left);
      p_tag  = tag_i;
      m_busy = 1;
      if (m_left == 0) begin m_q = p_q; m_r = p_r; m_tag = p_tag; end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("cyc_ready", {31'b0, ready_o}, {31'b0, !m_busy});
      check("cyc_valid", {31'b0, valid_o}, {31'b0, (m_busy && m_left == 0)});
      if (m_busy && m_left == 0) begin
        check("cyc_quot", quotient_o, m_q);
        check("cyc_rem", remainder_o, m_r);
        check("cyc_tag", {27'b0, tag_o}, {27'b0, m_tag});
      end
    end
  end

  task automatic run_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] t, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input int elat, input int hold);
    int lat;
    logic [W-1:0] hq, hr;
    @(negedge clk);
    valid_i = 1; signed_i = s; dividend_i = a; divisor_i = b; tag_i = t; ready_i = 0;
    @(posedge clk);
    @(negedge clk);
    valid_i = 0; dividend_i = $urandom; divisor_i = $urandom; signed_i = ~s;
    check("ready_low", {31'b0, ready_o}, 32'd0);
    lat = 0;
    while (!valid_o && lat < 100) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check("latency", 32'(lat), 32'(elat));
    check("quot", quotient_o, eq);
    check("rem", remainder_o, er);
    check("tag", {27'b0, tag_o}, {27'b0, t});
    hq = quotient_o; hr = remainder_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, valid_o}, 32'd1);
      check("hold_quot", quotient_o, hq);
      check("hold_rem", remainder_o, hr);
    end
    ready_i = 1;
    @(negedge clk);
    ready_i = 0;
    check("post_valid", {31'b0, valid_o}, 32'd0);
    check("post_ready", {31'b0, ready_o}, 32'd1);
    $display("op s=%0d %h / %h tag=%0d -> q=%h r=%h lat=%0d", s, a, b, t, hq, hr, lat);
  endtask

  initial begin
    #1;
    check("rst_valid", {31'b0, valid_o}, 32'd0);
    check("rst_quot", quotient_o, 32'd0);
    check("rst_rem", remainder_o, 32'd0);
    check("rst_tag", {27'b0, tag_o}, 32'd0);
    check("rst_ready", {31'b0, ready_o}, 32'd1);
    @(negedge clk); #2 rst = 1;

    run_op(0, 32'd100, 32'd7, 5'd3, 32'd14, 32'd2, 32, 0);
    run_op(1, 32'hFFFF_FFF9, 32'h2, 5'd4, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32, 0);
    run_op(1, 32'h7, 32'hFFFF_FFFE, 5'd5, 32'hFFFF_FFFD, 32'h1, 32, 0);
    run_op(0, 32'd5, 32'd0, 5'd6, 32'hFFFF_FFFF, 32'd5, 0, 0);
    run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 32'd0, 0, 0);
    run_op(1, 32'hFFFF_FFF7, 32'd0, 5'd8, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 0, 2);
    run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0, 32'h8000_0000, 32, 0);
    run_op(0, 32'hFFFF_FFFF, 32'h10, 5'd10, 32'h0FFF_FFFF, 32'hF, 32, 5);
    run_op(1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd31, 32'd14, 32'hFFFF_FFFE, 32, 0);

    // Flush at CALC cycle 10
    @(negedge clk);
    valid_i = 1; signed_i = 0; dividend_i = 32'd1000; divisor_i = 32'd3; tag_i = 5'd1;
    @(negedge clk); valid_i = 0;
    repeat (9) @(negedge clk);
    flush_i = 1;
    @(negedge clk); flush_i = 0;
    check("flush_ready", {31'b0, ready_o}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("flush_no_valid", {31'b0, valid_o}, 32'd0);
    end
    $display("flush mid-calc: op dropped");
    run_op(0, 32'd9, 32'd3, 5'd2, 32'd3, 32'd0, 32, 0);

    // Flush with a request in IDLE
    @(negedge clk);
    valid_i = 1; flush_i = 1; dividend_i = 32'd4; divisor_i = 32'd0;
    @(negedge clk); valid_i = 0; flush_i = 0;
    check("flush_idle_ready", {31'b0, ready_o}, 32'd1);
    check("flush_idle_valid", {31'b0, valid_o}, 32'd0);
    $display("flush in idle: request ignored");

    // Flush in DONE while ready_i is high
    @(negedge clk);
    valid_i = 1; signed_i = 0; dividend_i = 32'd20; divisor_i = 32'd0; tag_i = 5'd12;
    @(negedge clk); valid_i = 0;
    check("done_valid", {31'b0, valid_o}, 32'd1);
    flush_i = 1; ready_i = 1;
    @(negedge clk); flush_i = 0; ready_i = 0;
    check("flush_done_valid", {31'b0, valid_o}, 32'd0);
    check("flush_done_ready", {31'b0, ready_o}, 32'd1);
    $display("flush in done: result dropped");

    // Asynchronous reset mid-CALC
    @(negedge clk);
    valid_i = 1; signed_i = 0; dividend_i = 32'd77; divisor_i = 32'd5; tag_i = 5'd17;
    @(negedge clk); valid_i = 0;
    repeat (5) @(negedge clk);
    #2 rst = 0;
    #1;
    check("arst_valid", {31'b0, valid_o}, 32'd0);
    check("arst_quot", quotient_o, 32'd0);
    check("arst_rem", remainder_o, 32'd0);
    check("arst_tag", {27'b0, tag_o}, 32'd0);
    check("arst_ready", {31'b0, ready_o}, 32'd1);
    $display("async reset mid-calc: outputs cleared");
    @(negedge clk); #2 rst = 1;
    run_op(0, 32'd77, 32'd5, 5'd17, 32'd15, 32'd2, 32, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
